mergesort_accel: RTL and testbench
==================================

Name: mergesort_accel

Overview:
- Sorting accelerator that answers the pipeline's custom mergesort instruction (opcode 7'b1111111) on the start/done handshake.
- The pipeline loads an N-entry array through a write port and pulses start. The block runs a bottom-up, stable, ping-pong merge sort and pulses done.
- The pipeline stalls on busy and reads the result back through a combinational read port.

Parameters:
- N, 8: element count; power of two, 2 to 64.
- DATA_W, 32: element width in bits.
- ADDR_W, $clog2(N): index width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (low = reset).
- start  in  1  single-cycle request to sort; sampled in IDLE only.
- wr_en  in  1  array write strobe; ignored while busy.
- wr_addr  in  ADDR_W  write index.
- wr_data  in  DATA_W  write value.
- rd_addr  in  ADDR_W  read index.
- rd_data  out  DATA_W  result_bank[rd_addr], combinational; 0 while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sorted data is valid.

Behaviour:
- Storage: two banks, bank0[N] and bank1[N], plus a sel register naming the result bank.
  - Writes and reads always target bank[sel].
  - A sort starts from bank[sel] and leaves its result in the final destination bank; sel is updated to that bank.
- Reset (asynchronous, reset low):
  - state=IDLE, busy=0, done=0, sel=0.
  - Both banks cleared to 0.
  - All counters cleared.
  - rd_data therefore reads 0.
- FSM states: IDLE, MERGE, FINISH.
- IDLE:
  - start=1 -> MERGE; width=1, src=sel, out index k=0, run pointers i=0, j=1.
  - If wr_en and start are in the same cycle, the write lands first and is included in the sort.
- MERGE: writes exactly one element to bank[!src] per cycle.
  - Current pair covers lo=k rounded down to a multiple of 2*width; mid=lo+width; hi=lo+2*width.
  - If i<mid and (j>=hi or src[i]<=src[j]): take src[i], i++. Otherwise take src[j], j++.
  - Ties take the left run, so the sort is stable.
  - When k reaches hi, reload i=hi and j=hi+width for the next pair.
  - When k=N-1 is written, the pass ends: src flips, width doubles, k, i and j reload for the new width.
  - If the doubled width equals N, go to FINISH instead of starting another pass.
- FINISH: sel<=src (the final destination), done=1 for one cycle, busy=0, then -> IDLE.
- Latency: start sampled at edge 0; busy=1 after edge 0; done=1 after edge N*log2(N)+1.
  - N=8: done after edge 25.
  - busy falls in the same cycle done rises.
- Ignored while busy: start and wr_en; no effect on state or data.
- Reset low mid-sort: immediate return to the reset values above; partial results are lost.
- Compare is unsigned unless MERGESORT_SIGNED_EN is defined.
- No combinational path from start or wr_* to busy or done.

Optional Feature:
- Macro: MERGESORT_SIGNED_EN.
- Defined: elements are compared as two's-complement signed DATA_W values.
- Undefined: elements are compared as unsigned.
- Datapath, timing and ports are otherwise identical.

Test Plan:
- Basic sort: write [5,3,8,1,9,2,7,4] to indices 0-7, pulse start.
  - busy=1 after edge 0; done pulses after edge 25.
  - Reads 0-7 return [1,2,3,4,5,7,8,9]; busy=0.
- Duplicates and stability: write [4,4,2,2,9,0,9,0], sort.
  - Result [0,0,2,2,4,4,9,9].
  - Issue a second start without reloading: result unchanged, done again 25 edges later, sel toggles consistently.
- Pre-sorted and reverse input: [0..7] and [7..0].
  - Both return [0..7] with identical 25-edge latency.
- Busy protection: during the sort, pulse start and write wr_addr=0, wr_data=FFFF.
  - Single done pulse; result matches the basic-sort case; rd_data=0 while busy.
- Reset mid-operation: drive reset low at edge 10 of a sort.
  - busy=0, done=0, all reads 0; a fresh load and start then sorts correctly.
- Signedness: write [32'hFFFFFFFF, 1, 0, 32'h80000000, 2, 3, 4, 5].
  - Without MERGESORT_SIGNED_EN: first=0, last=32'hFFFFFFFF.
  - With it: first=32'h80000000, second=32'hFFFFFFFF, last=5.

Source files
------------

// File: rtl/mergesort_accel_if.sv
// Pipeline-side handshake and array access port for the mergesort accelerator.
// The pipeline drives through master; the accelerator uses slave.
interface mergesort_accel_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;

  modport master (
    output start, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, done
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, done
  );
endinterface

// File: rtl/mergesort_accel.sv
// Bottom-up stable ping-pong merge sort over two N-entry banks, one element per cycle.
// Define MERGESORT_SIGNED_EN to compare elements as two's-complement instead of unsigned.
module mergesort_accel #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input logic              clock,
  input logic              reset,
  mergesort_accel_if.slave bus
);

  // Run indices need to reach hi+width (up to 3N/2) without wrapping.
  localparam int IDX_W = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, MERGE, FINISH} state_t;

  state_t            state;
  logic              sel;
  logic              src;
  logic              busy_r;
  logic              done_r;
  logic [IDX_W-1:0]  width;
  logic [IDX_W-1:0]  i;
  logic [IDX_W-1:0]  j;
  logic [ADDR_W-1:0] k;

  logic [DATA_W-1:0] bank0 [N];
  logic [DATA_W-1:0] bank1 [N];

  function automatic logic le_fn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MERGESORT_SIGNED_EN
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    return sa <= sb;
`else
    return a <= b;
`endif
  endfunction

  logic [IDX_W-1:0]  k_x, width2, lo, mid, hi;
  logic [DATA_W-1:0] elem_i, elem_j, pick;
  logic              take_left;

  always_comb begin
    k_x       = IDX_W'(k);
    width2    = width << 1;
    lo        = k_x & ~(width2 - IDX_W'(1));
    mid       = lo + width;
    hi        = lo + width2;
    elem_i    = src ? bank1[i[ADDR_W-1:0]] : bank0[i[ADDR_W-1:0]];
    elem_j    = src ? bank1[j[ADDR_W-1:0]] : bank0[j[ADDR_W-1:0]];
    // Ties favour the left run, which keeps the sort stable.
    take_left = (i < mid) && ((j >= hi) || le_fn(elem_i, elem_j));
    pick      = take_left ? elem_i : elem_j;
  end

  logic              we0, we1;
  logic [ADDR_W-1:0] w_idx;
  logic [DATA_W-1:0] w_val;

  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    w_idx = '0;
    w_val = '0;
    if (state == IDLE && bus.wr_en) begin
      we0   = ~sel;
      we1   = sel;
      w_idx = bus.wr_addr;
      w_val = bus.wr_data;
    end else if (state == MERGE) begin
      we0   = src;
      we1   = ~src;
      w_idx = k;
      w_val = pick;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_bank
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        bank0[g] <= '0;
        bank1[g] <= '0;
      end else begin
        if (we0 && w_idx == ADDR_W'(g)) bank0[g] <= w_val;
        if (we1 && w_idx == ADDR_W'(g)) bank1[g] <= w_val;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sel    <= 1'b0;
      src    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      width  <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= MERGE;
            busy_r <= 1'b1;
            src    <= sel;
            width  <= IDX_W'(1);
            k      <= '0;
            i      <= '0;
            j      <= IDX_W'(1);
          end
        end
        MERGE: begin
          if (k == ADDR_W'(N - 1)) begin
            // Pass complete: destination becomes the next source.
            src   <= ~src;
            width <= width2;
            k     <= '0;
            i     <= '0;
            j     <= width2;
            if (width2 == IDX_W'(N)) state <= FINISH;
          end else if (k_x + IDX_W'(1) == hi) begin
            k <= k + ADDR_W'(1);
            i <= hi;
            j <= hi + width;
          end else begin
            k <= k + ADDR_W'(1);
            if (take_left) i <= i + IDX_W'(1);
            else           j <= j + IDX_W'(1);
          end
        end
        FINISH: begin
          sel    <= src;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rd_data = busy_r ? '0 : (sel ? bank1[bus.rd_addr] : bank0[bus.rd_addr]);

endmodule

// File: tb/tb_mergesort_accel.sv
// Bench for mergesort_accel: directed vector table, busy/reset corner cases, and random
// arrays checked against a plain insertion-sort reference (signedness follows MERGESORT_SIGNED_EN).
module tb_mergesort_accel;
  localparam int N      = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int LAT    = 25;

  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [N*DATA_W-1:0] pvec_t;

  typedef struct {
    string name;
    pvec_t din;
    pvec_t dout;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mergesort_accel_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mergesort_accel #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic pvec_t mk(input word_t a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic bit less(input word_t a, input word_t b);
`ifdef MERGESORT_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  task automatic model_sort(input pvec_t in, output pvec_t out);
    word_t a [N];
    word_t key;
    int    p;
    for (int n = 0; n < N; n++) a[n] = in[n*DATA_W +: DATA_W];
    for (int n = 1; n < N; n++) begin
      key = a[n];
      p   = n - 1;
      while (p >= 0 && less(key, a[p])) begin
        a[p+1] = a[p];
        p--;
      end
      a[p+1] = key;
    end
    out = '0;
    for (int n = 0; n < N; n++) out[n*DATA_W +: DATA_W] = a[n];
  endtask

  task automatic load(input pvec_t v);
    for (int n = 0; n < N; n++) begin
      @(negedge clock);
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(n);
      bus.wr_data = v[n*DATA_W +: DATA_W];
    end
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic read_all(input string name, input pvec_t exp);
    for (int n = 0; n < N; n++) begin
      bus.rd_addr = ADDR_W'(n);
      #1;
      check($sformatf("%s rd[%0d]", name, n), bus.rd_data, exp[n*DATA_W +: DATA_W]);
    end
  endtask

  // Start pulse sampled at edge 0; done is expected exactly LAT edges later.
  task automatic sort_run(input string name, input bit disturb);
    int lat;
    bit seen;
    logic busy_at_done;
    seen = 1'b0;
    lat  = 0;
    busy_at_done = 1'b1;
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    check({name, " busy after start"}, bus.busy, 1);
    for (int e = 1; e <= 60 && !seen; e++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        lat  = e;
        busy_at_done = bus.busy;
      end else if (disturb) begin
        if (e == 3) begin
          bus.start   = 1'b1;
          bus.wr_en   = 1'b1;
          bus.wr_addr = '0;
          bus.wr_data = 32'hFFFF;
        end
        if (e == 4) begin
          bus.start = 1'b0;
          bus.wr_en = 1'b0;
        end
        if (e == 6) begin
          bus.rd_addr = ADDR_W'(2);
          #1 check({name, " rd_data while busy"}, bus.rd_data, 0);
        end
      end
    end
    check({name, " done latency"}, lat, LAT);
    check({name, " busy at done"}, busy_at_done, 0);
    @(posedge clock);
    #1 check({name, " done single pulse"}, bus.done, 0);
  endtask

  vec_t  tbl [4];
  pvec_t v, expv;

  initial begin
    bus.start   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;

    tbl[0] = '{"basic",   mk(5,3,8,1,9,2,7,4), mk(1,2,3,4,5,7,8,9)};
    tbl[1] = '{"dups",    mk(4,4,2,2,9,0,9,0), mk(0,0,2,2,4,4,9,9)};
    tbl[2] = '{"sorted",  mk(0,1,2,3,4,5,6,7), mk(0,1,2,3,4,5,6,7)};
    tbl[3] = '{"reverse", mk(7,6,5,4,3,2,1,0), mk(0,1,2,3,4,5,6,7)};

    // Reset state
    #12;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    read_all("reset", '0);
    @(negedge clock);
    reset = 1'b1;

    for (int t = 0; t < 4; t++) begin
      load(tbl[t].din);
      sort_run(tbl[t].name, 1'b0);
      read_all(tbl[t].name, tbl[t].dout);
      if (t == 1) begin
        sort_run("dups resort", 1'b0);
        read_all("dups resort", tbl[t].dout);
      end
    end

    // Start and write during a sort must be ignored
    load(tbl[0].din);
    sort_run("busy prot", 1'b1);
    read_all("busy prot", tbl[0].dout);

    // Asynchronous reset in the middle of a sort
    load(tbl[0].din);
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("midreset busy", bus.busy, 0);
    check("midreset done", bus.done, 0);
    read_all("midreset", '0);
    @(negedge clock);
    reset = 1'b1;
    load(tbl[3].din);
    sort_run("after reset", 1'b0);
    read_all("after reset", tbl[3].dout);

    // Signedness
    v = mk(32'hFFFFFFFF, 1, 0, 32'h80000000, 2, 3, 4, 5);
    load(v);
    sort_run("sign", 1'b0);
`ifdef MERGESORT_SIGNED_EN
    expv = mk(32'h80000000, 32'hFFFFFFFF, 0, 1, 2, 3, 4, 5);
`else
    expv = mk(0, 1, 2, 3, 4, 5, 32'h80000000, 32'hFFFFFFFF);
`endif
    read_all("sign", expv);

    // Random arrays against the reference model
    for (int r = 0; r < 12; r++) begin
      for (int n = 0; n < N; n++)
        v[n*DATA_W +: DATA_W] = (r % 2 == 0) ? word_t'($urandom_range(0, 6)) : word_t'($urandom);
      model_sort(v, expv);
      load(v);
      sort_run($sformatf("rand%0d", r), 1'b0);
      read_all($sformatf("rand%0d", r), expv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
